// File: rtl/line_buffer_3row.sv
// line_buffer_3row: streaming 3-row vertical column generator.
// Two line RAMs hold lines y-1 and y-2 ahead of the Sobel stage.

module sync_ram_block #(
  parameter int WIDTH_P = 8,
  parameter int DEPTH_P = 640,
  parameter int AW_P    = $clog2(DEPTH_P)
) (
  input  logic               clk_i,
  input  logic               wr_en_i,
  input  logic [AW_P-1:0]    wr_addr_i,
  input  logic [WIDTH_P-1:0] wr_data_i,
  input  logic               rd_en_i,
  input  logic [AW_P-1:0]    rd_addr_i,
  output logic [WIDTH_P-1:0] rd_data_o
);

  logic [WIDTH_P-1:0] mem [DEPTH_P];

  // write port
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // registered read, output held while rd_en_i is low
  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      rd_data_o <= mem[rd_addr_i];
    end
  end

endmodule

module line_buffer_3row #(
  parameter int WIDTH_P  = 8,
  parameter int LINE_W_P = 640,
  parameter int IMG_H_P  = 480
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [WIDTH_P-1:0]           data_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [3*WIDTH_P-1:0]         col_o,
  output logic [$clog2(LINE_W_P)-1:0]  x_o,
  output logic [$clog2(IMG_H_P)-1:0]   y_o
);

  localparam int XW = $clog2(LINE_W_P);
  localparam int YW = $clog2(IMG_H_P);

  localparam logic [XW-1:0] X_LAST = XW'(LINE_W_P - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H_P - 1);
  localparam logic [YW-1:0] Y_OUT0 = YW'(2);

  typedef struct packed {
    logic [WIDTH_P-1:0] pix;
    logic [XW-1:0]      x;
    logic [YW-1:0]      y;
  } s1_t;

  logic               adv;
  logic               accept;
  logic               s1_fire;
  logic [XW-1:0]      x_cnt;
  logic [YW-1:0]      y_cnt;
  logic [XW-1:0]      x_nxt;
  logic [YW-1:0]      y_nxt;
  logic               x_wrap;
  logic               y_wrap;
  s1_t                s1_q;
  logic               s1_valid_q;
  logic [WIDTH_P-1:0] ram1_rd;
  logic [WIDTH_P-1:0] ram2_rd;

  assign adv     = ~valid_o | ready_i;
  assign ready_o = adv;
  assign accept  = valid_i & adv;
  assign s1_fire = adv & s1_valid_q;
  assign x_wrap  = (x_cnt == X_LAST);
  assign y_wrap  = (y_cnt == Y_LAST);

  // raster position of the next accepted pixel
  always_comb begin
    x_nxt = x_cnt;
    y_nxt = y_cnt;
    unique case (1'b1)
      !x_wrap: begin
        x_nxt = x_cnt + XW'(1);
      end
      x_wrap && !y_wrap: begin
        x_nxt = '0;
        y_nxt = y_cnt + YW'(1);
      end
      default: begin
        x_nxt = '0;
        y_nxt = '0;
      end
    endcase
  end

  // input x/y counters advance on each accepted pixel
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (accept) begin
      x_cnt <= x_nxt;
      y_cnt <= y_nxt;
    end
  end

  // stage 1 holds the pixel whose line data is being read
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (adv) begin
      s1_valid_q <= valid_i;
      if (valid_i) begin
        s1_q.pix <= data_i;
        s1_q.x   <= x_cnt;
        s1_q.y   <= y_cnt;
      end
    end
  end

  // output column register; first two lines only prime the RAMs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      col_o   <= '0;
      x_o     <= '0;
      y_o     <= '0;
    end else if (adv) begin
      valid_o <= s1_valid_q && (s1_q.y >= Y_OUT0);
      if (s1_valid_q) begin
        col_o <= {ram2_rd, ram1_rd, s1_q.pix};
        x_o   <= s1_q.x;
        y_o   <= s1_q.y;
      end
    end
  end

  sync_ram_block #(
    .WIDTH_P (WIDTH_P),
    .DEPTH_P (LINE_W_P),
    .AW_P    (XW)
  ) u_ram1 (
    .clk_i     (clk_i),
    .wr_en_i   (s1_fire),
    .wr_addr_i (s1_q.x),
    .wr_data_i (s1_q.pix),
    .rd_en_i   (accept),
    .rd_addr_i (x_cnt),
    .rd_data_o (ram1_rd)
  );

  sync_ram_block #(
    .WIDTH_P (WIDTH_P),
    .DEPTH_P (LINE_W_P),
    .AW_P    (XW)
  ) u_ram2 (
    .clk_i     (clk_i),
    .wr_en_i   (s1_fire),
    .wr_addr_i (s1_q.x),
    .wr_data_i (ram1_rd),
    .rd_en_i   (accept),
    .rd_addr_i (x_cnt),
    .rd_data_o (ram2_rd)
  );

endmodule

// File: tb/tb_line_buffer_3row.sv
// tb_line_buffer_3row: directed bench for line_buffer_3row.
// 4x4 frames, pixel = base + 16*y + x.

module tb_line_buffer_3row;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [7:0]  data_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [23:0] col_o;
  logic [1:0]  x_o;
  logic [1:0]  y_o;

  int errors = 0;
  int checks = 0;

  logic [23:0] col_q [$];
  logic [1:0]  x_q [$];
  logic [1:0]  y_q [$];

  typedef struct {
    logic        vin;
    logic [7:0]  din;
    logic        rin;
    logic        exp_valid;
    logic        exp_rdy;
    logic [23:0] exp_col;
    logic [1:0]  exp_x;
    logic [1:0]  exp_y;
  } vec_t;

  vec_t tbl [18];

  line_buffer_3row #(
    .WIDTH_P  (8),
    .LINE_W_P (4),
    .IMG_H_P  (4)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .col_o   (col_o),
    .x_o     (x_o),
    .y_o     (y_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pixval(input int p);
    int f;
    int k;
    f = p / 16;
    k = p % 16;
    return 8'((f % 2) * 128 + 16 * (k / 4) + (k % 4));
  endfunction

  function automatic logic [23:0] exp_col(input int j);
    int f;
    int r;
    int x;
    int y;
    int b;
    f = j / 8;
    r = j % 8;
    y = 2 + r / 4;
    x = r % 4;
    b = (f % 2) * 128;
    return {8'(b + 16 * (y - 2) + x),
            8'(b + 16 * (y - 1) + x),
            8'(b + 16 * y + x)};
  endfunction

  task automatic do_reset();
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    data_i  = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic run_stream(input int nframes,
                            input bit alt,
                            input bit stall_en);
    int p;
    int total;
    int want;
    int stall_left;
    bit stalled;
    p = 0;
    total = nframes * 16;
    want = nframes * 8;
    stall_left = 0;
    stalled = 1'b0;
    col_q.delete();
    x_q.delete();
    y_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk_i);
      if (stall_en && !stalled && valid_o &&
          x_o == 2'd1 && y_o == 2'd2) begin
        stalled = 1'b1;
        stall_left = 3;
      end
      ready_i = (stall_left == 0);
      valid_i = (p < total) && (!alt || cyc[0]);
      data_i  = pixval(p);
      #1;
      if (stall_left > 0) begin
        chk("stall_ready_o", 32'(ready_o), 32'd0);
        chk("stall_col_held", 32'(col_o), 32'h011121);
        stall_left--;
      end
      if (valid_o && ready_i) begin
        col_q.push_back(col_o);
        x_q.push_back(x_o);
        y_q.push_back(y_o);
      end
      if (valid_i && ready_o) p++;
      if (p == total && col_q.size() == want) break;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    if (stall_en) chk("stall_seen", 32'(stalled), 32'd1);
    chk("stream_count", 32'(col_q.size()), 32'(want));
    for (int j = 0; j < col_q.size() && j < want; j++) begin
      chk($sformatf("stream_col[%0d]", j), 32'(col_q[j]), 32'(exp_col(j)));
      chk($sformatf("stream_x[%0d]", j), 32'(x_q[j]), 32'(j % 4));
      chk($sformatf("stream_y[%0d]", j), 32'(y_q[j]), 32'(2 + (j % 8) / 4));
    end
    repeat (2) @(negedge clk_i);
    chk("stream_drained", 32'(valid_o), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 18; i++) begin
      int k;
      tbl[i].vin       = (i < 16);
      tbl[i].din       = (i < 16) ? pixval(i) : 8'h00;
      tbl[i].rin       = 1'b1;
      tbl[i].exp_rdy   = 1'b1;
      tbl[i].exp_valid = 1'b0;
      tbl[i].exp_col   = '0;
      tbl[i].exp_x     = '0;
      tbl[i].exp_y     = '0;
      if (i >= 1 && i <= 16) begin
        k = i - 1;
        tbl[i].exp_x = 2'(k % 4);
        tbl[i].exp_y = 2'(k / 4);
        if (k / 4 >= 2) begin
          tbl[i].exp_valid = 1'b1;
          tbl[i].exp_col = {8'(16 * (k / 4 - 2) + k % 4),
                            8'(16 * (k / 4 - 1) + k % 4),
                            8'(16 * (k / 4) + k % 4)};
        end
      end
    end

    do_reset();
    #1;
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_col_o", 32'(col_o), 32'd0);
    chk("rst_x_o", 32'(x_o), 32'd0);
    chk("rst_y_o", 32'(y_o), 32'd0);
    chk("rst_ready_o", 32'(ready_o), 32'd1);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk_i);
      valid_i = tbl[i].vin;
      data_i  = tbl[i].din;
      ready_i = tbl[i].rin;
      @(posedge clk_i);
      #1;
      chk($sformatf("t1_valid[%0d]", i), 32'(valid_o), 32'(tbl[i].exp_valid));
      chk($sformatf("t1_ready[%0d]", i), 32'(ready_o), 32'(tbl[i].exp_rdy));
      if (tbl[i].exp_valid) begin
        chk($sformatf("t1_col[%0d]", i), 32'(col_o), 32'(tbl[i].exp_col));
        chk($sformatf("t1_x[%0d]", i), 32'(x_o), 32'(tbl[i].exp_x));
        chk($sformatf("t1_y[%0d]", i), 32'(y_o), 32'(tbl[i].exp_y));
      end
      if (i == 8) chk("latency_not_early", 32'(valid_o), 32'd0);
      if (i == 9) chk("latency_first", 32'({valid_o, x_o, y_o}), 32'b1_00_10);
      if (i == 10) chk("line2_x1_col", 32'(col_o), 32'h011121);
      if (i == 16) chk("line3_x3_col", 32'(col_o), 32'h132333);
    end
    valid_i = 1'b0;

    do_reset();
    run_stream(1, 1'b0, 1'b1);

    do_reset();
    run_stream(1, 1'b1, 1'b0);

    do_reset();
    run_stream(2, 1'b0, 1'b0);

    do_reset();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk_i);
      valid_i = (i < 10);
      data_i  = pixval(i);
      ready_i = 1'b1;
    end
    @(negedge clk_i);
    valid_i = 1'b0;
    #1;
    chk("pre_rst_valid", 32'(valid_o), 32'd1);
    chk("pre_rst_x", 32'(x_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(valid_o), 32'd0);
    chk("mid_rst_xy", 32'({x_o, y_o}), 32'd0);
    chk("mid_rst_ready", 32'(ready_o), 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    run_stream(1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
